// File: rtl/comparator_operand_serializer.sv
// rtl/comparator_operand_serializer.sv - parallel operand pair to MSB-first bit-serial stream with first/last framing.
// Optional: define EARLY_EXIT_EN to end a pair on the first beat whose A and B bits differ.
module comparator_operand_serializer #(
  parameter int N     = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N:0]       a_in,
  input  logic [N:0]       b_in,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_a,
  output logic             ser_b,
  output logic             ser_first,
  output logic             ser_last,
  output logic             busy,
  output logic [CNT_W-1:0] pair_count
);

  localparam int CW = (N < 1) ? 1 : $clog2(N + 1);
  localparam logic [CW-1:0] CNT_TOP = CW'(N);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [N:0]       r_a_sh;
  logic [N:0]       r_b_sh;
  logic [CW-1:0]    r_bit_cnt;
  logic [CNT_W-1:0] r_pair_count;

  logic w_accept;
  logic w_beat;
  logic w_done;
  logic w_last_bit;

  // Final beat of the pair, decided purely from registered state.
`ifdef EARLY_EXIT_EN
  assign w_last_bit = (r_bit_cnt == '0) || (r_a_sh[N] != r_b_sh[N]);
`else
  assign w_last_bit = (r_bit_cnt == '0);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    ser_valid    = 1'b0;
    ser_a        = 1'b0;
    ser_b        = 1'b0;
    ser_first    = 1'b0;
    ser_last     = 1'b0;
    busy         = 1'b0;
    w_accept     = 1'b0;
    w_beat       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        w_accept = in_valid;
        if (in_valid) begin
          w_next_state = SHIFT;
        end
      end
      SHIFT: begin
        busy      = 1'b1;
        ser_valid = 1'b1;
        ser_a     = r_a_sh[N];
        ser_b     = r_b_sh[N];
        ser_first = (r_bit_cnt == CNT_TOP);
        ser_last  = w_last_bit;
        w_beat    = ser_ready;
        w_done    = ser_ready && w_last_bit;
        if (w_done) begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a_sh    <= '0;
      r_b_sh    <= '0;
      r_bit_cnt <= '0;
    end else if (w_accept) begin
      r_a_sh    <= a_in;
      r_b_sh    <= b_in;
      r_bit_cnt <= CNT_TOP;
    end else if (w_beat) begin
      r_a_sh    <= r_a_sh << 1;
      r_b_sh    <= r_b_sh << 1;
      r_bit_cnt <= r_bit_cnt - CW'(1);
    end
  end

  // Counts only pairs whose last beat was handshaked; wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pair_count <= '0;
    end else if (w_done) begin
      r_pair_count <= r_pair_count + CNT_W'(1);
    end
  end

  assign pair_count = r_pair_count;

endmodule

// File: tb/tb_comparator_operand_serializer.sv
// tb/tb_comparator_operand_serializer.sv - scoreboard bench for comparator_operand_serializer.
module tb_comparator_operand_serializer;

  localparam int N     = 3;
  localparam int CNT_W = 3;

  typedef struct {
    logic a;
    logic b;
    logic first;
    logic last;
  } beat_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [N:0]       a_in = '0;
  logic [N:0]       b_in = '0;
  logic             ser_valid;
  logic             ser_ready = 1'b0;
  logic             ser_a;
  logic             ser_b;
  logic             ser_first;
  logic             ser_last;
  logic             busy;
  logic [CNT_W-1:0] pair_count;

  beat_t            exp_q[$];
  logic [CNT_W-1:0] exp_cnt = '0;
  int               total = 0;
  int               bad = 0;
  int               ready_pct = 100;
  bit               garbage = 1'b0;

  comparator_operand_serializer #(.N(N), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .ser_valid(ser_valid), .ser_ready(ser_ready),
    .ser_a(ser_a), .ser_b(ser_b), .ser_first(ser_first), .ser_last(ser_last),
    .busy(busy), .pair_count(pair_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference: MSB-first bits, stopping at the first difference when early exit is built in.
  task automatic push_pair(input logic [N:0] a, input logic [N:0] b);
    beat_t bt;
    for (int i = N; i >= 0; i--) begin
      bt.a = a[i];
      bt.b = b[i];
      bt.first = (i == N);
      bt.last = (i == 0);
`ifdef EARLY_EXIT_EN
      if (a[i] != b[i]) bt.last = 1'b1;
`endif
      exp_q.push_back(bt);
      if (bt.last) break;
    end
  endtask

  always @(posedge clk) begin
    #1;
    ser_ready = ($urandom_range(0, 99) < ready_pct);
  end

  // Monitor: every negedge compares the DUT against the head of the scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      exp_cnt = '0;
    end else begin
      chk("ser_valid", ser_valid, exp_q.size() != 0);
      chk("busy", busy, exp_q.size() != 0);
      chk("in_ready", in_ready, exp_q.size() == 0);
      chk("pair_count", pair_count, exp_cnt);
      if (exp_q.size() != 0 && ser_valid) begin
        chk("ser_a", ser_a, exp_q[0].a);
        chk("ser_b", ser_b, exp_q[0].b);
        chk("ser_first", ser_first, exp_q[0].first);
        chk("ser_last", ser_last, exp_q[0].last);
        if (ser_ready) begin
          if (exp_q[0].last) exp_cnt = exp_cnt + 1'b1;
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic drive_pair(input logic [N:0] a, input logic [N:0] b);
    bit ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("accept_timeout", ok, 1'b1);
    in_valid = 1'b1;
    a_in = a;
    b_in = b;
    @(posedge clk);
    #1;
    if (ok) push_pair(a, b);
    if (garbage) begin
      in_valid = 1'b1;
      a_in = '1;
      b_in = '0;
    end else begin
      in_valid = 1'b0;
      a_in = N'($urandom);
      b_in = N'($urandom);
    end
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && in_ready) return;
    end
    chk("drain_timeout", 1'b0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N:0] ra;
    logic [N:0] rb;
    repeat (3) @(posedge clk);
    #3;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_ser_valid", ser_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_pair_count", pair_count, '0);
    chk("rst_ser_last", ser_last, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    ready_pct = 100;
    drive_pair(4'b1010, 4'b1001);
    drain();

    ready_pct = 40;
    drive_pair(4'b1010, 4'b1001);
    drain();

    garbage = 1'b1;
    ready_pct = 100;
    drive_pair(4'b1010, 4'b1001);
    drive_pair(4'b0110, 4'b0110);
    garbage = 1'b0;
    drain();

    ready_pct = 100;
    drive_pair(4'h5, 4'hA);
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_ser_valid", ser_valid, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_in_ready", in_ready, 1'b1);
    chk("arst_pair_count", pair_count, '0);
    exp_q.delete();
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    drive_pair(4'h5, 4'h5);
    drain();

    for (int p = 0; p < 9; p++) drive_pair(4'h3, 4'h3);
    drain();

    ready_pct = 60;
    for (int p = 0; p < 40; p++) begin
      garbage = $urandom_range(0, 1);
      ra = N'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : N'($urandom);
      drive_pair(ra, rb);
    end
    garbage = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/comparator_operand_serializer.md
Name: comparator_operand_serializer

Overview:
Upstream feeder for the bit-serial multi-bit comparator. It accepts one parallel operand pair (a, b) through a valid/ready handshake. It then presents the pair MSB-first, one bit pair per beat, on a serial valid/ready interface, with first/last framing so the comparator knows when to start and when to finish. It also counts completed operand pairs for debug and visibility.

Parameters:
N, 3, MSB index of each operand; operands are N+1 bits wide (N >= 0)
CNT_W, 8, width of the completed-pair counter

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  parallel operand pair valid
in_ready  output  1  block can accept a pair (high only in IDLE)
a_in  input  N+1  operand A
b_in  input  N+1  operand B
ser_valid  output  1  serial bit pair valid
ser_ready  input  1  downstream comparator accepts the current bit pair
ser_a  output  1  current bit of A (MSB first)
ser_b  output  1  current bit of B (MSB first)
ser_first  output  1  current beat is bit N (first beat of a pair)
ser_last  output  1  current beat is the final beat of a pair
busy  output  1  serialization in progress (state SHIFT)
pair_count  output  CNT_W  number of fully transmitted pairs, wraps modulo 2^CNT_W

Behaviour:
- Reset is asynchronous and active-high; both states below are clocked on rising clk.
- Reset values, held while reset is asserted:
  - state = IDLE; in_ready = 1
  - ser_valid, ser_a, ser_b, ser_first, ser_last, busy = 0
  - pair_count = 0; internal shift registers and bit counter = 0
- Reset mid-operation: the in-flight pair is abandoned with no partial completion, and pair_count is not incremented.
- IDLE:
  - in_ready = 1, ser_valid = 0.
  - On in_valid & in_ready: a_sh <= a_in, b_sh <= b_in, bit_cnt <= N, go to SHIFT.
- SHIFT:
  - in_ready = 0, busy = 1, ser_valid = 1.
  - ser_a = a_sh[N], ser_b = b_sh[N].
  - ser_first = (bit_cnt == N); ser_last = (bit_cnt == 0). When N = 0, both are high on the single beat.
  - Beat handshake is ser_valid & ser_ready. On a beat:
    - a_sh, b_sh shift left by 1 with zero fill; bit_cnt decrements.
    - If the beat was last: pair_count increments (wrapping) and state goes to IDLE.
- Stall: while ser_ready = 0, ser_a, ser_b, ser_first, ser_last and ser_valid hold stable; no state change.
- in_valid while busy is ignored (in_ready = 0); the operands are not sampled.
- Latency and throughput:
  - The first beat is presented the cycle after input acceptance.
  - With ser_ready held high, a pair occupies 1 accept cycle + N+1 beats.
  - Back-to-back throughput is one pair per N+2 cycles.
- ser_* outputs are decoded only from registered state and shift-register MSBs; there is no combinational path from in_valid/a_in/b_in to ser_*.
- bit_cnt width = clog2(N+1), minimum 1 bit.

Optional Feature:
Macro EARLY_EXIT_EN.
- Defined:
  - In SHIFT, ser_last is additionally asserted whenever ser_a != ser_b.
  - A handshaked beat with differing bits ends the pair: pair_count increments and state returns to IDLE. The remaining lower bits are never sent, since the comparator's result is already decided.
- Not defined: every pair always transmits exactly N+1 beats; ser_last depends only on bit_cnt.

Test Plan:
- N=3, reset released, in_valid=1, a_in=4'b1010, b_in=4'b1001, ser_ready=1 -> the cycle after acceptance, beats (a,b) = (1,1),(0,0),(1,0),(0,1); first flag on beat 0, last flag on beat 3; pair_count=1; in_ready returns 1 the following cycle. With EARLY_EXIT_EN the pair ends at beat 2 (a=1, b=0) with last=1.
- Stall: same pair, ser_ready=0 for 3 cycles during beat 1 -> ser_a=0, ser_b=0, ser_first=0 held for all 3 cycles; the sequence then continues unchanged; total beats = 4.
- Busy input: in_valid=1 with a_in=4'hF, b_in=4'h0 presented throughout the first pair -> in_ready=0 and the operands are ignored; the new pair is accepted only in the IDLE cycle after the last beat; pair_count reaches 2.
- Async reset asserted mid-beat 2 without a clock edge -> ser_valid=0, busy=0, in_ready=1, pair_count=0 immediately; after release, a fresh pair a=4'h5, b=4'h5 serializes as 4 equal beats and pair_count becomes 1.
- Wrap: CNT_W=2, 5 pairs with equal operands (a=b=4'h3) -> pair_count sequence 1,2,3,0,1.
- N=0 build: a_in=1, b_in=0 -> a single beat with ser_first=1, ser_last=1, ser_a=1, ser_b=0; pair_count=1.
